// File: rtl/sample_word_serializer.sv
// Parallel-to-serial feeder: buffers signed sample words in a FIFO and shifts
// each one out LSB first over a bit-level valid/ready link, with an idle gap between words.
module sample_word_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic [DATA_WIDTH-1:0]            i_word,
    input  logic                             i_word_valid,
    output logic                             o_word_ready,
    output logic                             o_dout,
    output logic                             o_dout_valid,
    input  logic                             i_ready,
    output logic                             o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]      r_bit;
    logic [GAP_W-1:0]      r_gap;

    logic w_push;
    logic w_pop;

    // Status decodes straight off registered state; valid is gated by enable.
    assign o_word_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign o_dout_valid = (r_state == S_SHIFT) && i_en;
    assign o_dout       = r_shift[0];
    assign o_busy       = (r_state != S_IDLE);
    assign o_fifo_count = r_count;

    assign w_push = i_word_valid && o_word_ready && !i_rst;
    assign w_pop  = (r_state == S_LOAD) && i_en;

    // Storage array carries no reset; pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serial FSM; everything on this side freezes while i_en is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift <= r_mem[r_rd_ptr];
                    r_bit   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (i_ready) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + BIT_W'(1);
                        if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                            r_gap   <= '0;
                            r_state <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GAP_W'(1);
                    if (r_gap == GAP_W'(GAP_LAST)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_word_serializer.sv
// Bench for sample_word_serializer: transaction-level model checked every cycle,
// directed scenarios with literal expectations, random traffic, and a zero-gap instance.
module tb_sample_word_serializer;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] word = '0;
    logic          word_valid = 1'b0;
    logic          ready = 1'b0;
    logic          word_ready, dout, dout_valid, busy;
    logic [CW-1:0] fifo_count;

    logic          en0 = 1'b0;
    logic [DW-1:0] word0 = '0;
    logic          word_valid0 = 1'b0;
    logic          ready0 = 1'b0;
    logic          word_ready0, dout0, dout_valid0, busy0;
    logic [CW-1:0] fifo_count0;

    sample_word_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_word(word), .i_word_valid(word_valid),
        .o_word_ready(word_ready), .o_dout(dout), .o_dout_valid(dout_valid),
        .i_ready(ready), .o_busy(busy), .o_fifo_count(fifo_count)
    );

    sample_word_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) u_dut_nogap (
        .i_clk(clk), .i_rst(rst), .i_en(en0), .i_word(word0), .i_word_valid(word_valid0),
        .o_word_ready(word_ready0), .o_dout(dout0), .o_dout_valid(dout_valid0),
        .i_ready(ready0), .o_busy(busy0), .o_fifo_count(fifo_count0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a word queue plus a per-word step index.
    // -1 idle, 0 load, 1..DW presenting bit (step-1), DW+1..DW+GAP gap.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_cur = '0;
    int            m_step = -1;
    bit            m_init = 1'b0;

    always @(posedge clk) begin : model
        bit push;
        if (rst) begin
            m_q.delete();
            m_step = -1;
            m_cur  = '0;
            m_init = 1'b1;
        end else if (m_init) begin
            push = word_valid && (m_q.size() < DEPTH);
            if (en) begin
                if (m_step == -1) begin
                    if (m_q.size() != 0) m_step = 0;
                end else if (m_step == 0) begin
                    m_cur  = m_q.pop_front();
                    m_step = 1;
                end else if (m_step <= DW) begin
                    if (ready) m_step++;
                end else begin
                    m_step++;
                end
                if (m_step > DW + GAP) m_step = -1;
            end
            if (push) m_q.push_back(word);
        end
    end

    always @(negedge clk) begin : compare
        bit shifting;
        if (m_init) begin
            shifting = (m_step >= 1) && (m_step <= DW);
            check("dout_valid", 32'(dout_valid), 32'(shifting && en));
            check("busy", 32'(busy), 32'(m_step != -1));
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("word_ready", 32'(word_ready), 32'(m_q.size() != DEPTH));
            if (shifting) check("dout", 32'(dout), 32'(m_cur[m_step-1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!dout_valid && k < 60) begin
            k++;
            tick();
        end
        check(name, 32'(dout_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy || fifo_count != '0) && k < 2000) begin
            k++;
            tick();
        end
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " count"}, 32'(fifo_count), 32'd0);
    endtask

    task automatic recv_window(output int len, output logic [DW-1:0] w);
        len = 0;
        w   = '0;
        while (dout_valid && len < 200) begin
            if (len < DW) w[len] = dout;
            len++;
            tick();
        end
    endtask

    task automatic low_run(output int len);
        len = 0;
        while (!dout_valid && len < 60) begin
            len++;
            tick();
        end
    endtask

    logic [DW-1:0] t2 [3];
    logic [DW-1:0] t4 [17];
    logic [DW-1:0] acc, prev_dout;
    int            len, low, got, k;
    bit            prev_ready, held_ok, valid_ok, seen;

    initial begin
        t2[0] = 24'hA5F00F;
        t2[1] = 24'h800000;
        t2[2] = 24'h7FFFFF;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        check("rst dout_valid", 32'(dout_valid), 32'd0);
        check("rst dout", 32'(dout), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(fifo_count), 32'd0);
        check("rst word_ready", 32'(word_ready), 32'd1);
        rst   = 1'b0;
        en    = 1'b1;
        ready = 1'b1;
        tick();

        // Single word 0x000001: latency, window length, gap length
        word = 24'h000001;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        check("t1 count after write", 32'(fifo_count), 32'd1);
        check("t1 valid N+0", 32'(dout_valid), 32'd0);
        tick();
        check("t1 valid N+1", 32'(dout_valid), 32'd0);
        check("t1 busy N+1", 32'(busy), 32'd1);
        tick();
        check("t1 valid N+2", 32'(dout_valid), 32'd1);
        check("t1 first bit", 32'(dout), 32'd1);
        recv_window(len, acc);
        check("t1 window len", 32'(len), 32'd24);
        check("t1 word", 32'(acc), 32'h000001);
        low = 0;
        while (busy && !dout_valid && low < 60) begin
            low++;
            tick();
        end
        check("t1 gap len", 32'(low), 32'd2);
        check("t1 busy after gap", 32'(busy), 32'd0);

        // Three words back to back
        word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word = t2[i];
            tick();
        end
        word_valid = 1'b0;
        wait_valid("t2 start");
        for (int i = 0; i < 3; i++) begin
            recv_window(len, acc);
            check("t2 window len", 32'(len), 32'd24);
            check("t2 word", 32'(acc), 32'(t2[i]));
            if (i < 2) begin
                low_run(low);
                check("t2 inter-word low", 32'(low), 32'(GAP + 2));
            end
        end
        wait_idle("t2 idle");

        // Downstream backpressure 1,0,0,1
        word = 24'h123456;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        wait_valid("t3 start");
        got = 0; k = 0; acc = '0;
        prev_ready = 1'b1; prev_dout = '0; held_ok = 1'b1; valid_ok = 1'b1;
        while (got < DW && k < 500) begin
            ready = ((k % 4) == 0) || ((k % 4) == 3);
            if (!dout_valid) valid_ok = 1'b0;
            if (k > 0 && !prev_ready && (dout !== prev_dout[0])) held_ok = 1'b0;
            if (ready) begin
                acc[got] = dout;
                got++;
            end
            prev_ready   = ready;
            prev_dout[0] = dout;
            tick();
            k++;
        end
        ready = 1'b1;
        check("t3 bits received", 32'(got), 32'd24);
        check("t3 valid held", 32'(valid_ok), 32'd1);
        check("t3 bit held on stall", 32'(held_ok), 32'd1);
        check("t3 word", 32'(acc), 32'h123456);
        check("t3 valid after last bit", 32'(dout_valid), 32'd0);
        wait_idle("t3 idle");

        // Fill with serial side disabled, 17th write dropped, then drain
        en = 1'b0;
        word_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            t4[i] = DW'($urandom);
            word  = t4[i];
            check("t4 word_ready before write", 32'(word_ready), 32'(i < DEPTH));
            tick();
        end
        word_valid = 1'b0;
        check("t4 count full", 32'(fifo_count), 32'd16);
        check("t4 word_ready full", 32'(word_ready), 32'd0);
        check("t4 no output while disabled", 32'(dout_valid), 32'd0);
        en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_valid("t4 word start");
            recv_window(len, acc);
            check("t4 window len", 32'(len), 32'd24);
            check("t4 word order", 32'(acc), 32'(t4[i]));
        end
        wait_idle("t4 idle");

        // Reset in the middle of a word with three queued behind it
        word_valid = 1'b1;
        word = 24'hFFFFFF; tick();
        word = 24'h000011; tick();
        word = 24'h000022; tick();
        word = 24'h000033; tick();
        word_valid = 1'b0;
        wait_valid("t5 start");
        while (busy && !dout_valid) tick();
        got = 0;
        while (got < 10 && dout_valid) begin
            got++;
            tick();
        end
        check("t5 on bit 10", 32'(got), 32'd10);
        check("t5 count queued", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 dout_valid", 32'(dout_valid), 32'd0);
        check("t5 dout", 32'(dout), 32'd0);
        check("t5 count", 32'(fifo_count), 32'd0);
        check("t5 word_ready", 32'(word_ready), 32'd1);
        check("t5 busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (60) begin
            if (dout_valid) seen = 1'b1;
            tick();
        end
        check("t5 no output after reset", 32'(seen), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            en         = ($urandom_range(0, 9) != 0);
            ready      = ($urandom_range(0, 9) < 7);
            word_valid = ($urandom_range(0, 2) == 0);
            word       = DW'($urandom);
            rst        = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; en = 1'b1; ready = 1'b1; word_valid = 1'b0;
        wait_idle("random drain");

        // Zero-gap instance: only IDLE and LOAD separate words
        en0 = 1'b1;
        ready0 = 1'b1;
        word_valid0 = 1'b1;
        word0 = 24'h0F0F0F; tick();
        word0 = 24'hC3C3C3; tick();
        word_valid0 = 1'b0;
        k = 0;
        while (!dout_valid0 && k < 20) begin
            k++;
            tick();
        end
        check("t6 start", 32'(dout_valid0), 32'd1);
        for (int i = 0; i < 2; i++) begin
            len = 0; acc = '0;
            while (dout_valid0 && len < 100) begin
                if (len < DW) acc[len] = dout0;
                len++;
                tick();
            end
            check("t6 window len", 32'(len), 32'd24);
            check("t6 word", 32'(acc), (i == 0) ? 32'h0F0F0F : 32'hC3C3C3);
            if (i == 0) begin
                low = 0;
                while (!dout_valid0 && low < 20) begin
                    low++;
                    tick();
                end
                check("t6 inter-word low", 32'(low), 32'd2);
            end
        end
        repeat (3) tick();
        check("t6 busy end", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
